// File: rtl/pipelined_barrel_shifter_if.sv
// Handshake bundle for the pipelined barrel shifter: operand/control in, result/tag out.
// Latency: none, this is wiring only.
// Backpressure: in_ready/out_ready carry stall information between producer and unit.
interface pipelined_barrel_shifter_if #(
    parameter int WIDTH = 32,
    parameter int TAG_W = 5
);
    localparam int SHAMT_W = $clog2(WIDTH);

    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   data_input;
    logic [SHAMT_W-1:0] ctrl_shiftamt;
    logic [1:0]         ctrl_mode;
    logic [TAG_W-1:0]   in_tag;
    logic               out_valid;
    logic               out_ready;
    logic [WIDTH-1:0]   data_result;
    logic [TAG_W-1:0]   out_tag;
`ifdef SHIFTER_STATUS_EN
    logic               out_zero;
    logic               out_carry;

    modport master (
        output in_valid, data_input, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
        input  in_ready, out_valid, data_result, out_tag, out_zero, out_carry
    );
    modport slave (
        input  in_valid, data_input, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
        output in_ready, out_valid, data_result, out_tag, out_zero, out_carry
    );
`else
    modport master (
        output in_valid, data_input, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
        input  in_ready, out_valid, data_result, out_tag
    );
    modport slave (
        input  in_valid, data_input, ctrl_shiftamt, ctrl_mode, in_tag, out_ready,
        output in_ready, out_valid, data_result, out_tag
    );
`endif
endinterface

// File: rtl/pipelined_barrel_shifter.sv
// Pipelined barrel shifter (SLL/SRL/SRA/ROR) with tag sideband; SHIFTER_STATUS_EN adds out_zero/out_carry.
// Latency: ceil(SHAMT_W/REG_EVERY) cycles from accepted input to out_valid, one op per cycle.
// Backpressure: the whole pipe freezes while out_valid && !out_ready; in_ready is the inverse of that stall.
module pipelined_barrel_shifter #(
    parameter int WIDTH     = 32,
    parameter int REG_EVERY = 2,
    parameter int TAG_W     = 5
) (
    input logic                       clock,
    input logic                       reset,
    pipelined_barrel_shifter_if.slave bus
);
    localparam int SHAMT_W = $clog2(WIDTH);
    localparam int NSTG    = (SHAMT_W + REG_EVERY - 1) / REG_EVERY;

    localparam logic [1:0] MODE_SLL = 2'b00;
    localparam logic [1:0] MODE_SRL = 2'b01;
    localparam logic [1:0] MODE_SRA = 2'b10;

    logic stall;

    // One mux level: shift by amt in the selected mode. SRA fills with the
    // sign of the original operand, which travels down the pipe alongside.
    function automatic logic [WIDTH-1:0] lvl_shift(input logic [WIDTH-1:0] d,
                                                   input logic [1:0]       mode,
                                                   input logic             sign,
                                                   input int               amt);
        logic [WIDTH-1:0] res;
        logic [WIDTH-1:0] fill;
        fill = sign ? ~({WIDTH{1'b1}} >> amt) : '0;
        case (mode)
            MODE_SLL: res = d << amt;
            MODE_SRL: res = d >> amt;
            MODE_SRA: res = (d >> amt) | fill;
            default:  res = (d >> amt) | (d << (WIDTH - amt));
        endcase
        return res;
    endfunction

`ifdef SHIFTER_STATUS_EN
    // Last bit to leave the word at this level. For ROR that bit lands in
    // the MSB, which is the same bit as the right-shift case.
    function automatic logic lvl_carry(input logic [WIDTH-1:0] d,
                                       input logic [1:0]       mode,
                                       input int               amt);
        logic [WIDTH-1:0] lo_side;
        logic [WIDTH-1:0] hi_side;
        lo_side = d >> (amt - 1);
        hi_side = d << (amt - 1);
        return (mode == MODE_SLL) ? hi_side[WIDTH-1] : lo_side[0];
    endfunction
`endif

    for (genvar s = 0; s < NSTG; s++) begin : g_stg
        localparam int LO   = s * REG_EVERY;
        localparam int RW   = SHAMT_W - LO;
        localparam int NLVL = (RW < REG_EVERY) ? RW : REG_EVERY;
        localparam bit LAST = (s == NSTG - 1);

        logic             v_in;
        logic [WIDTH-1:0] d_in;
        logic [RW-1:0]    sh_in;
        logic [RW-1:0]    sh_bits;
        logic [1:0]       mode_in;
        logic             sign_in;
        logic [TAG_W-1:0] tag_in;
        logic [WIDTH-1:0] data_d;
        logic             vld_q;
        logic [WIDTH-1:0] data_q;
        logic [TAG_W-1:0] tag_q;
`ifdef SHIFTER_STATUS_EN
        logic             c_in;
        logic             carry_d;
        logic             carry_q;
`endif

        if (s == 0) begin : g_src
            assign v_in    = bus.in_valid;
            assign d_in    = bus.data_input;
            assign sh_in   = bus.ctrl_shiftamt;
            assign mode_in = bus.ctrl_mode;
            assign sign_in = bus.data_input[WIDTH-1];
            assign tag_in  = bus.in_tag;
`ifdef SHIFTER_STATUS_EN
            assign c_in    = 1'b0;
`endif
        end else begin : g_link
            assign v_in    = g_stg[s-1].vld_q;
            assign d_in    = g_stg[s-1].data_q;
            assign sh_in   = g_stg[s-1].g_ctl.sh_q;
            assign mode_in = g_stg[s-1].g_ctl.mode_q;
            assign sign_in = g_stg[s-1].g_ctl.sign_q;
            assign tag_in  = g_stg[s-1].tag_q;
`ifdef SHIFTER_STATUS_EN
            assign c_in    = g_stg[s-1].carry_q;
`endif
        end

        // Apply this stage's mux levels; level (LO+j) shifts by 2^(LO+j)
        always_comb begin
            data_d  = d_in;
            sh_bits = '0;
`ifdef SHIFTER_STATUS_EN
            carry_d = c_in;
`endif
            for (int j = 0; j < NLVL; j++) begin
                sh_bits = sh_in >> j;
                if (sh_bits[0]) begin
`ifdef SHIFTER_STATUS_EN
                    carry_d = lvl_carry(data_d, mode_in, 1 << (LO + j));
`endif
                    data_d = lvl_shift(data_d, mode_in, sign_in, 1 << (LO + j));
                end
            end
        end

        // Stage register bank: advances with the whole pipe, holds on stall
        always_ff @(posedge clock) begin
            if (!reset) begin
                vld_q   <= 1'b0;
                data_q  <= '0;
                tag_q   <= '0;
`ifdef SHIFTER_STATUS_EN
                carry_q <= 1'b0;
`endif
            end else if (!stall) begin
                vld_q   <= v_in;
                data_q  <= data_d;
                tag_q   <= tag_in;
`ifdef SHIFTER_STATUS_EN
                carry_q <= carry_d;
`endif
            end
        end

        if (!LAST) begin : g_ctl
            logic [RW-REG_EVERY-1:0] sh_q;
            logic [1:0]              mode_q;
            logic                    sign_q;

            // Forward only the shift-amount bits later stages still consume
            always_ff @(posedge clock) begin
                if (!reset) begin
                    sh_q   <= '0;
                    mode_q <= '0;
                    sign_q <= 1'b0;
                end else if (!stall) begin
                    sh_q   <= sh_in[RW-1:REG_EVERY];
                    mode_q <= mode_in;
                    sign_q <= sign_in;
                end
            end
        end
    end

    // The final bank doubles as the output register
    assign stall           = g_stg[NSTG-1].vld_q && !bus.out_ready;
    assign bus.in_ready    = !stall;
    assign bus.out_valid   = g_stg[NSTG-1].vld_q;
    assign bus.data_result = g_stg[NSTG-1].data_q;
    assign bus.out_tag     = g_stg[NSTG-1].tag_q;

`ifdef SHIFTER_STATUS_EN
    logic zero_q;

    // Zero flag registered alongside the final data bank
    always_ff @(posedge clock) begin
        if (!reset) begin
            zero_q <= 1'b0;
        end else if (!stall) begin
            zero_q <= (g_stg[NSTG-1].data_d == '0);
        end
    end

    assign bus.out_zero  = zero_q;
    assign bus.out_carry = g_stg[NSTG-1].carry_q;
`endif
endmodule

// File: tb/tb_pipelined_barrel_shifter.sv
module tb_pipelined_barrel_shifter;
    typedef struct packed {
        logic [31:0] d;
        logic [4:0]  t;
        logic        z;
        logic        c;
    } exp_t;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    pipelined_barrel_shifter_if #(.WIDTH(32), .TAG_W(5)) b32 ();
    pipelined_barrel_shifter_if #(.WIDTH(16), .TAG_W(5)) b16 ();

    pipelined_barrel_shifter #(.WIDTH(32), .REG_EVERY(2), .TAG_W(5)) dut32 (
        .clock(clk), .reset(rst_n), .bus(b32)
    );
    pipelined_barrel_shifter #(.WIDTH(16), .REG_EVERY(1), .TAG_W(5)) dut16 (
        .clock(clk), .reset(rst_n), .bus(b16)
    );

    int   checks   = 0;
    int   failures = 0;
    int   cycle_n  = 0;
    exp_t q32[$];
    exp_t q16[$];
    int   pops32[$];
    exp_t pend32, pend16;
    logic acc32 = 1'b0, acc16 = 1'b0;
    logic hold32 = 1'b0, hold16 = 1'b0;
    logic [31:0] hd32;
    logic [15:0] hd16;
    logic [4:0]  ht32, ht16;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic exp_t mk(input logic [31:0] d, input logic [4:0] t, input logic z, input logic c);
        exp_t e;
        e.d = d; e.t = t; e.z = z; e.c = c;
        return e;
    endfunction

    // Whole-word reference: shift the full operand at once in a 64-bit container
    function automatic exp_t model(input logic [63:0] din, input int amt, input logic [1:0] mode,
                                   input int w, input logic [4:0] tag);
        logic [63:0] mask, d, sx, r, tmp;
        logic c;
        exp_t e;
        mask = (64'd1 << w) - 64'd1;
        d    = din & mask;
        tmp  = d >> (w - 1);
        sx   = tmp[0] ? (d | ~mask) : d;
        case (mode)
            2'b00:   r = (d << amt) & mask;
            2'b01:   r = d >> amt;
            2'b10:   r = (sx >> amt) & mask;
            default: r = ((d >> amt) | (d << (w - amt))) & mask;
        endcase
        if (amt == 0)            c = 1'b0;
        else if (mode == 2'b00) begin tmp = d >> (w - amt); c = tmp[0]; end
        else if (mode == 2'b11) begin tmp = r >> (w - 1);   c = tmp[0]; end
        else                    begin tmp = d >> (amt - 1); c = tmp[0]; end
        e.d = r[31:0]; e.t = tag; e.z = (r == 64'd0); e.c = c;
        return e;
    endfunction

    // One clock: called at a negedge with inputs settled; scores outputs, logs accepts
    task automatic cyc();
        exp_t e;
        #1;
        if (rst_n) begin
            if (hold32) begin
                chk("hold32_data", b32.data_result, hd32);
                chk("hold32_tag", {27'd0, b32.out_tag}, {27'd0, ht32});
            end
            if (b32.out_valid && !b32.out_ready) chk("stall32_in_ready", {31'd0, b32.in_ready}, 32'd0);
            if (b32.out_valid && b32.out_ready) begin
                if (q32.size() == 0) chk("spurious32", {31'd0, b32.out_valid}, 32'd0);
                else begin
                    e = q32.pop_front();
                    pops32.push_back(cycle_n);
                    chk("res32_data", b32.data_result, e.d);
                    chk("res32_tag", {27'd0, b32.out_tag}, {27'd0, e.t});
`ifdef SHIFTER_STATUS_EN
                    chk("res32_zero", {31'd0, b32.out_zero}, {31'd0, e.z});
                    chk("res32_carry", {31'd0, b32.out_carry}, {31'd0, e.c});
`endif
                end
            end
            if (hold16) begin
                chk("hold16_data", {16'd0, b16.data_result}, {16'd0, hd16});
                chk("hold16_tag", {27'd0, b16.out_tag}, {27'd0, ht16});
            end
            if (b16.out_valid && !b16.out_ready) chk("stall16_in_ready", {31'd0, b16.in_ready}, 32'd0);
            if (b16.out_valid && b16.out_ready) begin
                if (q16.size() == 0) chk("spurious16", {31'd0, b16.out_valid}, 32'd0);
                else begin
                    e = q16.pop_front();
                    chk("res16_data", {16'd0, b16.data_result}, {16'd0, e.d[15:0]});
                    chk("res16_tag", {27'd0, b16.out_tag}, {27'd0, e.t});
`ifdef SHIFTER_STATUS_EN
                    chk("res16_zero", {31'd0, b16.out_zero}, {31'd0, e.z});
                    chk("res16_carry", {31'd0, b16.out_carry}, {31'd0, e.c});
`endif
                end
            end
        end
        acc32 = rst_n && b32.in_valid && b32.in_ready;
        acc16 = rst_n && b16.in_valid && b16.in_ready;
        if (acc32) q32.push_back(pend32);
        if (acc16) q16.push_back(pend16);
        hold32 = rst_n && b32.out_valid && !b32.out_ready;
        hold16 = rst_n && b16.out_valid && !b16.out_ready;
        hd32 = b32.data_result; ht32 = b32.out_tag;
        hd16 = b16.data_result; ht16 = b16.out_tag;
        cycle_n++;
        @(negedge clk);
    endtask

    task automatic drive32(input logic [1:0] m, input logic [31:0] d, input int a,
                           input logic [4:0] t, input exp_t e);
        b32.in_valid = 1'b1; b32.data_input = d; b32.ctrl_shiftamt = 5'(a);
        b32.ctrl_mode = m; b32.in_tag = t; pend32 = e;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (acc32) break;
        end
        if (!acc32) chk("accept32_timeout", {31'd0, acc32}, 32'd1);
    endtask

    task automatic drive16(input logic [1:0] m, input logic [15:0] d, input int a,
                           input logic [4:0] t, input exp_t e);
        b16.in_valid = 1'b1; b16.data_input = d; b16.ctrl_shiftamt = 4'(a);
        b16.ctrl_mode = m; b16.in_tag = t; pend16 = e;
        for (int k = 0; k < 50; k++) begin
            cyc();
            if (acc16) break;
        end
        if (!acc16) chk("accept16_timeout", {31'd0, acc16}, 32'd1);
    endtask

    task automatic drain();
        b32.in_valid = 1'b0; b16.in_valid = 1'b0;
        b32.out_ready = 1'b1; b16.out_ready = 1'b1;
        for (int k = 0; k < 100; k++) begin
            if (q32.size() == 0 && q16.size() == 0) break;
            cyc();
        end
        chk("drain32_left", q32.size(), 32'd0);
        chk("drain16_left", q16.size(), 32'd0);
    endtask

    initial begin
        int lat;
        int a;
        logic [1:0] m;
        logic [31:0] d;
        logic [4:0] t;

        // Reset held 3 cycles with in_valid asserted
        rst_n = 1'b0;
        b32.in_valid = 1'b1; b32.data_input = 32'hDEADBEEF; b32.ctrl_shiftamt = 5'd3;
        b32.ctrl_mode = 2'b00; b32.in_tag = 5'd9; b32.out_ready = 1'b1;
        b16.in_valid = 1'b1; b16.data_input = 16'hBEEF; b16.ctrl_shiftamt = 4'd3;
        b16.ctrl_mode = 2'b00; b16.in_tag = 5'd9; b16.out_ready = 1'b1;
        repeat (3) begin
            @(posedge clk); #1;
            chk("rst32_valid", {31'd0, b32.out_valid}, 32'd0);
            chk("rst32_data", b32.data_result, 32'd0);
            chk("rst32_tag", {27'd0, b32.out_tag}, 32'd0);
            chk("rst16_valid", {31'd0, b16.out_valid}, 32'd0);
            chk("rst16_data", {16'd0, b16.data_result}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1; b32.in_valid = 1'b0; b16.in_valid = 1'b0;
        @(posedge clk); #1;
        chk("post_rst32_in_ready", {31'd0, b32.in_ready}, 32'd1);
        chk("post_rst16_in_ready", {31'd0, b16.in_ready}, 32'd1);
        @(negedge clk);

        // Single SRA, latency 3
        drive32(2'b10, 32'h80000000, 4, 5'd3, mk(32'hF8000000, 5'd3, 1'b0, 1'b0));
        b32.in_valid = 1'b0;
        lat = 1;
        while (!b32.out_valid && lat < 20) begin cyc(); lat++; end
        chk("latency32", lat, 32'd3);
        drain();

        // Back-to-back four ops, results on consecutive cycles
        pops32.delete();
        drive32(2'b00, 32'h00000001, 31, 5'd10, mk(32'h80000000, 5'd10, 1'b0, 1'b0));
        drive32(2'b01, 32'hF0000000, 4,  5'd11, mk(32'h0F000000, 5'd11, 1'b0, 1'b0));
        drive32(2'b11, 32'h00000001, 1,  5'd12, mk(32'h80000000, 5'd12, 1'b0, 1'b1));
        drive32(2'b10, 32'h12345678, 0,  5'd13, mk(32'h12345678, 5'd13, 1'b0, 1'b0));
        drain();
        chk("b2b_count", pops32.size(), 32'd4);
        if (pops32.size() == 4) chk("b2b_spacing", pops32[3] - pops32[0], 32'd3);

        // Fill pipe with consumer stalled, hold 5 cycles, then release
        b32.out_ready = 1'b0;
        drive32(2'b00, 32'h000000FF, 8,  5'd20, model(64'h000000FF, 8,  2'b00, 32, 5'd20));
        drive32(2'b01, 32'h80000001, 31, 5'd21, model(64'h80000001, 31, 2'b01, 32, 5'd21));
        drive32(2'b11, 32'h0000000F, 4,  5'd22, model(64'h0000000F, 4,  2'b11, 32, 5'd22));
        b32.in_valid = 1'b1; b32.data_input = 32'hFFFFFFF0; b32.ctrl_shiftamt = 5'd4;
        b32.ctrl_mode = 2'b10; b32.in_tag = 5'd23;
        pend32 = model(64'hFFFFFFF0, 4, 2'b10, 32, 5'd23);
        repeat (5) begin
            cyc();
            chk("stall32_no_accept", {31'd0, acc32}, 32'd0);
        end
        b32.out_ready = 1'b1;
        drive32(2'b10, 32'hFFFFFFF0, 4, 5'd23, model(64'hFFFFFFF0, 4, 2'b10, 32, 5'd23));
        drain();

        // Reset with three operations in flight
        drive32(2'b00, 32'hA5A5A5A5, 3, 5'd1, model(64'hA5A5A5A5, 3, 2'b00, 32, 5'd1));
        drive32(2'b01, 32'h5A5A5A5A, 5, 5'd2, model(64'h5A5A5A5A, 5, 2'b01, 32, 5'd2));
        drive32(2'b11, 32'h0F0F0F0F, 7, 5'd4, model(64'h0F0F0F0F, 7, 2'b11, 32, 5'd4));
        b32.in_valid = 1'b0;
        rst_n = 1'b0;
        q32.delete(); q16.delete();
        cyc(); cyc();
        rst_n = 1'b1;
        cyc();
        chk("flush32_valid", {31'd0, b32.out_valid}, 32'd0);
        drive32(2'b10, 32'hC0000001, 1, 5'd30, model(64'hC0000001, 1, 2'b10, 32, 5'd30));
        drain();

        // 16-bit, one level per stage
        drive16(2'b11, 16'h8001, 15, 5'd7, mk(32'h00000003, 5'd7, 1'b0, 1'b0));
        b16.in_valid = 1'b0;
        lat = 1;
        while (!b16.out_valid && lat < 20) begin cyc(); lat++; end
        chk("latency16", lat, 32'd4);
        drive16(2'b10, 16'h8000, 15, 5'd8, mk(32'h0000FFFF, 5'd8, 1'b0, 1'b0));
        drive16(2'b01, 16'h0001, 1,  5'd9, mk(32'h00000000, 5'd9, 1'b1, 1'b1));
        drain();

        // Random traffic on both units with random backpressure
        b32.in_valid = 1'b0; b16.in_valid = 1'b0;
        for (int cy = 0, n32 = 0, n16 = 0; cy < 300; cy++) begin
            if (!b32.in_valid || acc32) begin
                if ($urandom_range(0, 3) != 0 && n32 < 60) begin
                    d = $urandom; a = $urandom_range(0, 31); m = 2'($urandom_range(0, 3)); t = 5'($urandom);
                    b32.data_input = d; b32.ctrl_shiftamt = 5'(a); b32.ctrl_mode = m; b32.in_tag = t;
                    pend32 = model({32'd0, d}, a, m, 32, t);
                    b32.in_valid = 1'b1; n32++;
                end else b32.in_valid = 1'b0;
            end
            if (!b16.in_valid || acc16) begin
                if ($urandom_range(0, 3) != 0 && n16 < 60) begin
                    d = {16'd0, 16'($urandom)}; a = $urandom_range(0, 15); m = 2'($urandom_range(0, 3)); t = 5'($urandom);
                    b16.data_input = d[15:0]; b16.ctrl_shiftamt = 4'(a); b16.ctrl_mode = m; b16.in_tag = t;
                    pend16 = model({32'd0, d}, a, m, 16, t);
                    b16.in_valid = 1'b1; n16++;
                end else b16.in_valid = 1'b0;
            end
            b32.out_ready = ($urandom_range(0, 3) != 0);
            b16.out_ready = ($urandom_range(0, 3) != 0);
            cyc();
        end
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/pipelined_barrel_shifter.md
Name: pipelined_barrel_shifter

Overview:
- Parametrised, pipelined barrel shifter. Generalises the fixed 32-bit arithmetic-right shifter.
- Selectable mode: logical left, logical right, arithmetic right, rotate right.
- Configurable width and register placement, with a valid/ready handshake and backpressure.
- Sits in the execute stage as a multicycle functional unit beside the ALU. A tag field carries the destination register number through the pipe.

Parameters:
- WIDTH, 32, data width in bits; power of two, 8..64.
- SHAMT_W, $clog2(WIDTH), shift-amount width; derived, never overridden.
- REG_EVERY, 2, number of mux levels between pipeline registers; legal values 1..SHAMT_W.
- TAG_W, 5, width of the sideband tag passed alongside the data.

Ports:
- clock  in  1  system clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-low reset.
- in_valid  in  1  input operation present.
- in_ready  out  1  unit accepts an input this cycle.
- data_input  in  WIDTH  operand.
- ctrl_shiftamt  in  SHAMT_W  shift amount, 0..WIDTH-1.
- ctrl_mode  in  2  00 SLL, 01 SRL, 10 SRA, 11 ROR.
- in_tag  in  TAG_W  sideband tag.
- out_valid  out  1  result present.
- out_ready  in  1  consumer accepts the result.
- data_result  out  WIDTH  shifted result.
- out_tag  out  TAG_W  tag matching data_result.

Behaviour:
- Structure:
  - SHAMT_W mux levels; level k shifts by 2^k when ctrl_shiftamt[k] is set.
  - A register bank sits after every REG_EVERY levels, plus a final output register. The final register is merged with the last boundary if they coincide.
  - Latency L = ceil(SHAMT_W/REG_EVERY) cycles, from accepted input to out_valid. Example: WIDTH=32, REG_EVERY=2 gives L=3.
- Per-stage contents: valid bit, partial data, remaining shamt bits, mode, tag (plus status, if enabled).
- Mode rules:
  - SLL: zero-fill from the LSB side.
  - SRL: zero-fill from the MSB side.
  - SRA: every level fills with the sign bit of the original data_input. The sign bit is carried through the pipe; it is not re-read from the partial data.
  - ROR: bits leaving the LSB side re-enter at the MSB side.
- Shift amount 0 in any mode: data_result = data_input.
- Handshake:
  - Input is accepted when in_valid && in_ready.
  - Output is consumed when out_valid && out_ready.
  - Stall: the pipe stalls as a whole when out_valid && !out_ready.
  - in_ready = !(out_valid && !out_ready).
  - When not stalled, every stage advances each cycle. Empty slots (bubbles) propagate with their valid bit = 0; there is no bubble collapsing.
  - While stalled, all stage registers hold, including data_result and out_tag. data_result and out_tag must stay stable while out_valid && !out_ready.
- Throughput: one operation per cycle when out_ready is held high.
- Reset (reset = 0 at a clock edge):
  - All valid bits clear. out_valid = 0, data_result = 0, out_tag = 0. All stage data clears to 0.
  - in_ready = 1 on the first cycle after reset deasserts.
  - Reset mid-operation discards every in-flight operation; nothing from before reset appears at the output.
- Simultaneous events:
  - Input accept and output consume in the same cycle are both honoured.
  - in_valid while stalled: the operand is not accepted; the source must hold it.
- No combinational path from in_valid or data_input to any output. in_ready depends combinationally on out_ready only.

Optional Feature:
- Macro: SHIFTER_STATUS_EN.
- When defined:
  - Adds output ports out_zero (1 bit) and out_carry (1 bit), registered and aligned with data_result.
  - out_zero = (data_result == 0).
  - out_carry = last bit shifted out: SLL gives data_input[WIDTH-shamt], SRL/SRA give data_input[shamt-1], ROR gives data_result[WIDTH-1]. It is 0 when shamt = 0.
  - Both flags reset to 0 and hold during a stall.
- When undefined: the ports and their logic are absent. All other behaviour is identical.

Test Plan:
- Reset held low 3 cycles with in_valid=1 driven -> out_valid=0, data_result=0, out_tag=0 throughout; in_ready=1 on the cycle after release.
- Defaults, out_ready=1; SRA 0x80000000 by 4, tag 3 -> after exactly 3 cycles data_result=0xF8000000, out_tag=3; carry=0, zero=0 if enabled.
- Back-to-back inputs on 4 consecutive cycles: SLL 0x00000001 by 31; SRL 0xF0000000 by 4; ROR 0x00000001 by 1; SRA 0x12345678 by 0 -> results 0x80000000, 0x0F000000, 0x80000000, 0x12345678 on 4 consecutive cycles, tags in order.
- Pipe full, out_ready=0 for 5 cycles -> in_ready=0, data_result/out_tag frozen, no loss or duplication; out_ready=1 then drains in order.
- Reset asserted with 3 operations in flight -> none emerges; the first result after reset is from the first post-reset input.
- REG_EVERY=1, WIDTH=16: ROR 0x8001 by 15 -> 0x0003 after 4 cycles; SRA 0x8000 by 15 -> 0xFFFF; with SHIFTER_STATUS_EN, SRL 0x0001 by 1 -> result 0x0000, out_zero=1, out_carry=1.
